// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between an op initiator and the ALU execution unit.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 2
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_sel;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_out;
   logic             rsp_zero;
   logic             rsp_carry;
   logic             rsp_ovf;
   logic             rsp_error;

   // Initiator side: issues ops and consumes responses
   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry, rsp_ovf, rsp_error
   );

   // Responder side: the execution unit
   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry, rsp_ovf, rsp_error
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered, handshaked ALU wrapper: accept one op, compute for one cycle,
// hold the response until taken, and keep saturating op/error counters.
module alu_exec_unit #(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_exec_unit_if.slave       bus,
   output logic [CNT_WIDTH-1:0] op_count,
   output logic [CNT_WIDTH-1:0] err_count
);
   localparam int unsigned Msb = WIDTH - 1;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e               state_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2:0]           sel_q;
   logic                 req_ready_q, rsp_valid_q;
   logic [WIDTH-1:0]     out_q;
   logic                 zero_q, carry_q, ovf_q, error_q;
   logic [CNT_WIDTH-1:0] op_cnt_q, err_cnt_q;

   logic [WIDTH:0]       sum, diff;
   logic [WIDTH-1:0]     res_d;
   logic                 zero_d, carry_d, ovf_d, error_d;

   // Result and flags from the latched operands; only sampled in EXEC
   always_comb begin
      sum     = {1'b0, a_q} + {1'b0, b_q};
      diff    = {1'b0, a_q} - {1'b0, b_q};
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      error_d = 1'b0;
      case (sel_q)
         3'b000: begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
         end
         3'b001: begin
            res_d   = diff[WIDTH-1:0];
            // Bit WIDTH of the widened difference is the unsigned borrow (a < b)
            carry_d = diff[WIDTH];
            ovf_d   = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
         end
         3'b010:  res_d = a_q & b_q;
         3'b011:  res_d = a_q | b_q;
         default: error_d = 1'b1;
      endcase
      zero_d = !error_d && (res_d == '0);
   end

   // Control FSM with registered handshake, response and counter outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         out_q       <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         error_q     <= 1'b0;
         op_cnt_q    <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               req_ready_q <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  a_q         <= bus.req_a;
                  b_q         <= bus.req_b;
                  sel_q       <= bus.req_sel;
                  req_ready_q <= 1'b0;
                  state_q     <= StExec;
               end
            end
            StExec: begin
               out_q       <= res_d;
               zero_q      <= zero_d;
               carry_q     <= carry_d;
               ovf_q       <= ovf_d;
               error_q     <= error_d;
               rsp_valid_q <= 1'b1;
               state_q     <= StResp;
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
                  if (op_cnt_q != '1) op_cnt_q <= op_cnt_q + CNT_WIDTH'(1);
                  if (error_q && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_q     <= StIdle;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_out   = out_q;
   assign bus.rsp_zero  = zero_q;
   assign bus.rsp_carry = carry_q;
   assign bus.rsp_ovf   = ovf_q;
   assign bus.rsp_error = error_q;
   assign op_count      = op_cnt_q;
   assign err_count     = err_cnt_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=2), plus a CNT_WIDTH=2 instance for saturation.
module tb_alu_exec_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_exec_unit_if #(.WIDTH(2)) bus ();
   alu_exec_unit_if #(.WIDTH(2)) bus2 ();

   logic [7:0] op_count, err_count;
   logic [1:0] op_count2, err_count2;

   alu_exec_unit #(.WIDTH(2), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .op_count  (op_count),
      .err_count (err_count)
   );

   alu_exec_unit #(.WIDTH(2), .CNT_WIDTH(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus2),
      .op_count  (op_count2),
      .err_count (err_count2)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int exp_ops = 0;
   int exp_errs = 0;
   logic [5:0] got;

   // Wait (bounded) for req_ready, present one request, deassert after the accept edge
   task automatic issue(input logic [1:0] a, input logic [1:0] b, input logic [2:0] sel,
                        input string name);
      int waits = 0;
      while (bus.req_ready !== 1'b1 && waits < 10) begin
         @(posedge clk); #1;
         waits++;
      end
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept: req_ready=%b required 1", name, bus.req_ready);
      end
      bus.req_a = a;
      bus.req_b = b;
      bus.req_sel = sel;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Bounded wait for rsp_valid
   task automatic wait_rsp(input string name);
      int waits = 0;
      while (bus.rsp_valid !== 1'b1 && waits < 10) begin
         @(posedge clk); #1;
         waits++;
      end
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s rsp_valid wait: got %b required 1", name, bus.rsp_valid);
      end
   endtask

   // Consume the response with a one-cycle rsp_ready pulse
   task automatic take();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      exp_ops++;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf,
           bus.rsp_error, op_count, err_count} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b vld=%b out=%b cnt=%0d/%0d required all 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_out, op_count, err_count);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
      end
   endtask

   task automatic test_add();
      issue(2'b01, 2'b01, 3'b000, "add");
      n_cmp++;
      if (bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_latency_early: rsp_valid=%b required 0", bus.rsp_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL add_latency: rsp_valid=%b required 1", bus.rsp_valid);
      end
      got = {bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_error};
      n_cmp++;
      if (got !== 6'b100010) begin
         n_fail++;
         $display("FAIL add_01_01: {out,z,c,v,e}=%b required 100010", got);
      end
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ready_in_resp: req_ready=%b required 0", bus.req_ready);
      end
      take();
      n_cmp++;
      if (op_count !== 8'(exp_ops) || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL add_take: op_count=%0d rsp_valid=%b required %0d and 0",
                  op_count, bus.rsp_valid, exp_ops);
      end
   endtask

   // ADD/SUB corner cases and AND/OR, as a small table
   task automatic test_arith_logic();
      logic [1:0] a, b;
      logic [2:0] sel;
      logic [5:0] exp;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       begin a = 2'b11; b = 2'b01; sel = 3'b000; exp = 6'b001100; end
            1:       begin a = 2'b11; b = 2'b01; sel = 3'b001; exp = 6'b100000; end
            2:       begin a = 2'b00; b = 2'b01; sel = 3'b001; exp = 6'b110100; end
            3:       begin a = 2'b11; b = 2'b01; sel = 3'b010; exp = 6'b010000; end
            default: begin a = 2'b10; b = 2'b01; sel = 3'b011; exp = 6'b110000; end
         endcase
         issue(a, b, sel, "arith");
         wait_rsp("arith");
         got = {bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_error};
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL arith_%0d sel=%b a=%b b=%b: {out,z,c,v,e}=%b required %b",
                     i, sel, a, b, got, exp);
         end
         take();
      end
      n_cmp++;
      if (op_count !== 8'(exp_ops) || err_count !== 8'(exp_errs)) begin
         n_fail++;
         $display("FAIL arith_counts: op=%0d err=%0d required %0d %0d",
                  op_count, err_count, exp_ops, exp_errs);
      end
   endtask

   task automatic test_error();
      issue(2'b11, 2'b11, 3'b100, "error");
      wait_rsp("error");
      got = {bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_error};
      n_cmp++;
      if (got !== 6'b000001) begin
         n_fail++;
         $display("FAIL error_flags: {out,z,c,v,e}=%b required 000001", got);
      end
      n_cmp++;
      if (err_count !== 8'(exp_errs)) begin
         n_fail++;
         $display("FAIL error_count_before: got %0d required %0d", err_count, exp_errs);
      end
      take();
      exp_errs++;
      n_cmp++;
      if (op_count !== 8'(exp_ops) || err_count !== 8'(exp_errs)) begin
         n_fail++;
         $display("FAIL error_counts: op=%0d err=%0d required %0d %0d",
                  op_count, err_count, exp_ops, exp_errs);
      end
   endtask

   task automatic test_backpressure();
      issue(2'b10, 2'b10, 3'b010, "bp");
      wait_rsp("bp");
      // A competing request while the response is held must be ignored
      bus.req_a = 2'b11;
      bus.req_b = 2'b11;
      bus.req_sel = 3'b000;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         got = {bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf, bus.rsp_error};
         n_cmp++;
         if (got !== 6'b100000 || bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
             op_count !== 8'(exp_ops)) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: rsp=%b vld=%b rdy=%b op=%0d required 100000 1 0 %0d",
                     i, got, bus.rsp_valid, bus.req_ready, op_count, exp_ops);
         end
      end
      bus.req_valid = 1'b0;
      take();
      n_cmp++;
      if (op_count !== 8'(exp_ops) || bus.rsp_valid !== 1'b0 || bus.rsp_out !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_release: op=%0d vld=%b out=%b required %0d 0 10",
                  op_count, bus.rsp_valid, bus.rsp_out, exp_ops);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stray_req: vld=%b rdy=%b required 0 1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_reset_in_exec();
      issue(2'b01, 2'b10, 3'b011, "rst_exec");
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_ovf,
           bus.rsp_error, op_count, err_count} !== 24'h0) begin
         n_fail++;
         $display("FAIL rst_exec_outputs: rdy=%b vld=%b out=%b cnt=%0d/%0d required all 0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_out, op_count, err_count);
      end
      exp_ops = 0;
      exp_errs = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_exec_release: rdy=%b vld=%b required 1 0",
                  bus.req_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_saturation();
      int waits;
      logic [1:0] exp;
      for (int i = 1; i <= 5; i++) begin
         waits = 0;
         while (bus2.req_ready !== 1'b1 && waits < 10) begin
            @(posedge clk); #1;
            waits++;
         end
         bus2.req_a = 2'b01;
         bus2.req_b = 2'b01;
         bus2.req_sel = 3'b111;
         bus2.req_valid = 1'b1;
         @(posedge clk); #1;
         bus2.req_valid = 1'b0;
         waits = 0;
         while (bus2.rsp_valid !== 1'b1 && waits < 10) begin
            @(posedge clk); #1;
            waits++;
         end
         bus2.rsp_ready = 1'b1;
         @(posedge clk); #1;
         bus2.rsp_ready = 1'b0;
         exp = (i >= 3) ? 2'b11 : 2'(i);
         n_cmp++;
         if (op_count2 !== exp || err_count2 !== exp) begin
            n_fail++;
            $display("FAIL sat_op_%0d: op=%b err=%b required %b %b",
                     i, op_count2, err_count2, exp, exp);
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_sel = '0;
      bus.rsp_ready = 1'b0;
      bus2.req_valid = 1'b0;
      bus2.req_a = '0;
      bus2.req_b = '0;
      bus2.req_sel = '0;
      bus2.rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_arith_logic();
      test_error();
      test_backpressure();
      test_reset_in_exec();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
